mult_vector_recorder: RTL and testbench
=======================================

Name: mult_vector_recorder

Overview:
- Hardware capture buffer for the multiplier datapath: records {a, b, y} triples on the chip while the datapath runs.
- Triples are packed into VEC_W-bit words using the same bit layout as the offline test-vector files (a in the MSBs, then b, then y).
- Captured words are read back sequentially for dump and comparison.
- Sits beside param_mult in the FDCT datapath as the producer/writer end of the vector flow that our benches consume.

Parameters:
- WIDTH_IN, 8: width of each multiplier operand a, b.
- WIDTH_OUT, 16: width of multiplier result y.
- DEPTH, 1024: number of vector words stored; power of two.
- ADDR_W, 10: log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse: start a new capture.
- stop  in  1  single-cycle pulse: end the capture early.
- cap_valid  in  1  a/b/y are valid this cycle; record them.
- a  in  WIDTH_IN  operand a.
- b  in  WIDTH_IN  operand b.
- y  in  WIDTH_OUT  product.
- rd_en  in  1  request the next stored word.
- rd_data  out  VEC_W  read word {a,b,y}, where VEC_W = 2*WIDTH_IN+WIDTH_OUT (32 by default).
- rd_valid  out  1  rd_data is valid this cycle.
- rd_last  out  1  marks the final stored word; asserted together with rd_valid.
- count  out  ADDR_W+1  number of words captured.
- capturing  out  1  high while in CAPTURE.
- done  out  1  high while in DONE (capture complete, readout allowed).

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE; count=0; wr_ptr=0; rd_ptr=0.
  - rd_valid=0, rd_last=0, rd_data=0, capturing=0, done=0.
  - Memory contents are not cleared.
- States: IDLE, CAPTURE, DONE, DRAIN.
- IDLE:
  - arm -> CAPTURE; clears count, wr_ptr and rd_ptr.
  - cap_valid, stop and rd_en are ignored.
- CAPTURE:
  - Each cycle with cap_valid: mem[wr_ptr] <= {a,b,y}; wr_ptr++, count++.
  - count reaching DEPTH -> DONE on the same edge as the final write. Later cap_valid is dropped and count saturates at DEPTH.
  - stop -> DONE. If stop and cap_valid arrive in the same cycle, the word is written first.
  - arm while in CAPTURE is ignored.
- DONE:
  - If count==0: done stays high and the first rd_en returns rd_valid=0 and goes to IDLE.
  - Otherwise rd_en reads mem[rd_ptr] and rd_ptr++.
  - Read latency is one cycle: rd_data/rd_valid appear on the cycle after rd_en.
  - On the read of index count-1, the FSM moves to DRAIN.
  - arm in DONE is ignored, so unread captures cannot be lost.
- DRAIN:
  - One cycle; presents the last word with rd_valid=1 and rd_last=1.
  - Then returns to IDLE. rd_en in this cycle is ignored.
- rd_valid is a single-cycle pulse per accepted rd_en. rd_data holds its last value when rd_valid=0.
- rd_en outside DONE has no effect.
- The memory is a synchronous-read, single-write-port array; reads and writes never overlap by construction.
- Reset in any state aborts immediately. The next arm starts a fresh capture from address 0.

Test Plan:
- arm, then 3 cap_valid cycles: (3,5,15), (255,255,65025), (0,7,0); stop; 3 rd_en -> rd_data=0x0305000F, 0xFFFFFE01, 0x00070000; rd_last only on the third; count=3; back to IDLE.
- arm, 1024 consecutive cap_valid with a=i[7:0], b=1 -> done on the 1024th edge; extra cap_valid ignored; count=1024; full readout matches; rd_last on word 1023.
- Same-cycle stop and cap_valid (2,2,4) after two prior writes -> count=3; last read word 0x02020004.
- arm then immediate stop -> done=1, count=0; rd_en -> rd_valid stays 0, FSM to IDLE.
- Reset asserted mid-CAPTURE after 5 writes -> all outputs 0 asynchronously, before the next edge; arm plus 1 write -> count=1; readout returns the new word at index 0.
- rd_en and arm pulsed during CAPTURE and DONE respectively -> no rd_valid, no restart; count unchanged.

Source files
------------

// File: rtl/mult_vector_recorder.sv
// Capture buffer for the multiplier datapath: records {a,b,y} triples into an
// on-chip array during CAPTURE and plays them back one word per rd_en in DONE.
module mult_vector_recorder #(
  parameter  int WIDTH_IN  = 8,
  parameter  int WIDTH_OUT = 16,
  parameter  int DEPTH     = 1024,
  parameter  int ADDR_W    = 10,
  localparam int VEC_W     = 2 * WIDTH_IN + WIDTH_OUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 stop,
  input  logic                 cap_valid,
  input  logic [WIDTH_IN-1:0]  a,
  input  logic [WIDTH_IN-1:0]  b,
  input  logic [WIDTH_OUT-1:0] y,
  input  logic                 rd_en,
  output logic [VEC_W-1:0]     rd_data,
  output logic                 rd_valid,
  output logic                 rd_last,
  output logic [ADDR_W:0]      count,
  output logic                 capturing,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE, DRAIN} state_t;

  localparam logic [ADDR_W:0] FULL_M1 = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [VEC_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   last_idx;
  logic              arm_fire, wr_fire, full_fire, rd_fire, rd_fin, empty_exit;

  // Qualified events; everything below is keyed off these.
  always_comb begin
    arm_fire   = (state == IDLE) && arm;
    wr_fire    = (state == CAPTURE) && cap_valid;
    full_fire  = wr_fire && (count == FULL_M1);
    rd_fire    = (state == DONE) && rd_en && (count != '0);
    empty_exit = (state == DONE) && rd_en && (count == '0);
    last_idx   = count - (ADDR_W + 1)'(1);
    rd_fin     = rd_fire && ({1'b0, rd_ptr} == last_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    capturing = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        capturing = 1'b1;
        if (stop || full_fire) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (empty_exit)  state_nxt = IDLE;
        else if (rd_fin) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_last  <= rd_fin;
      if (arm_fire) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (rd_fire) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: the array deliberately has no reset; clearing it would block RAM
  // inference, and count bounds what is ever read back.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= {a, b, y};
  end

endmodule

// File: tb/tb_mult_vector_recorder.sv
// Self-checking bench for mult_vector_recorder: directed scenarios plus random
// captures, compared against a queue-based model of the recorded vectors.
module tb_mult_vector_recorder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset;
  logic        arm, stop, cap_valid, rd_en;
  logic [7:0]  a, b;
  logic [15:0] y;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, capturing, done;
  logic [10:0] count;

  int checks = 0;
  int errors = 0;

  // Model: words recorded so far, plus whether capture / readout is open.
  logic [31:0] q[$];
  bit          m_cap  = 0;
  bit          m_done = 0;
  logic [31:0] last_word = '0;

  mult_vector_recorder dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .stop      (stop),
    .cap_valid (cap_valid),
    .a         (a),
    .b         (b),
    .y         (y),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .count     (count),
    .capturing (capturing),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word layout by arithmetic: a weighs 2^24, b 2^16, y 2^0.
  function automatic logic [31:0] pack(input int av, input int bv, input int yv);
    return 32'(av * 16777216 + bv * 65536 + yv);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    if (!m_cap && !m_done) begin
      q.delete();
      m_cap = 1;
    end
  endtask

  task automatic do_cap(input int av, input int bv, input int yv, input bit cv, input bit st);
    a = 8'(av); b = 8'(bv); y = 16'(yv);
    cap_valid = cv;
    stop = st;
    tick();
    cap_valid = 1'b0;
    stop = 1'b0;
    if (m_cap) begin
      if (cv && q.size() < DEPTH) q.push_back(pack(av, bv, yv));
      if (st || q.size() == DEPTH) begin
        m_cap  = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_capturing"}, 32'(capturing), 32'(m_cap));
    check({tag, "_done"}, 32'(done), 32'(m_done));
  endtask

  task automatic read_all(input bit gaps);
    int n = q.size();
    int i = 0;
    if (n == 0) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("empty_rd_valid", 32'(rd_valid), 32'd0);
      check("empty_done", 32'(done), 32'd0);
      m_done = 0;
      return;
    end
    while (i < n) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        tick();
        check("gap_rd_valid", 32'(rd_valid), 32'd0);
        check("gap_rd_data_hold", rd_data, last_word);
      end else begin
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rd_valid", 32'(rd_valid), 32'd1);
        check("rd_data", rd_data, q[i]);
        check("rd_last", 32'(rd_last), 32'(i == n - 1));
        check("rd_done", 32'(done), 32'(i != n - 1));
        last_word = q[i];
        i++;
      end
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    m_done = 0;
    check("post_rd_valid", 32'(rd_valid), 32'd0);
    check("post_rd_last", 32'(rd_last), 32'd0);
    check("post_rd_data_hold", rd_data, last_word);
    check_status("post_idle");
  endtask

  initial begin
    reset = 1'b1;
    arm = 0; stop = 0; cap_valid = 0; rd_en = 0;
    a = '0; b = '0; y = '0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;

    // Inputs other than arm are ignored while idle.
    do_cap(9, 9, 81, 1, 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("idle_rd_valid", 32'(rd_valid), 32'd0);
    check_status("idle");

    // Three directed triples, then stop.
    do_arm();
    check_status("t1_arm");
    do_cap(3, 5, 15, 1, 0);
    do_cap(255, 255, 65025, 1, 0);
    do_cap(0, 7, 0, 1, 0);
    do_cap(0, 0, 0, 0, 1);
    check_status("t1_stop");
    check("t1_count3", 32'(count), 32'd3);
    check("t1_w0", q[0], 32'h0305000F);
    check("t1_w1", q[1], 32'hFFFFFE01);
    check("t1_w2", q[2], 32'h00070000);
    read_all(0);

    // Stop and cap_valid on the same cycle: the word is kept.
    do_arm();
    do_cap(1, 1, 1, 1, 0);
    do_cap(1, 2, 2, 1, 0);
    do_cap(2, 2, 4, 1, 1);
    check_status("t3");
    check("t3_count3", 32'(count), 32'd3);
    read_all(0);
    check("t3_last_word", rd_data, 32'h02020004);

    // Immediate stop: empty capture.
    do_arm();
    do_cap(0, 0, 0, 0, 1);
    check_status("t4");
    read_all(0);

    // Asynchronous reset in the middle of a capture.
    do_arm();
    for (int i = 0; i < 5; i++) do_cap(i, i + 1, i * (i + 1), 1, 0);
    check("t5_pre_count", 32'(count), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_capturing", 32'(capturing), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_rd_data", rd_data, 32'd0);
    check("t5_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("t5_rst_rd_last", 32'(rd_last), 32'd0);
    tick();
    reset = 1'b0;
    q.delete(); m_cap = 0; m_done = 0; last_word = '0;
    do_arm();
    do_cap(17, 3, 51, 1, 0);
    do_cap(0, 0, 0, 0, 1);
    check_status("t5_new");
    read_all(0);

    // rd_en during CAPTURE and arm during DONE change nothing.
    do_arm();
    do_cap(4, 4, 16, 1, 0);
    rd_en = 1'b1;
    do_cap(5, 6, 30, 1, 0);
    rd_en = 1'b0;
    check("t6_cap_rd_valid", 32'(rd_valid), 32'd0);
    do_cap(0, 0, 0, 0, 1);
    do_arm();
    check_status("t6_done_arm");
    read_all(0);

    // Fill to DEPTH; extra writes are dropped.
    do_arm();
    for (int i = 0; i < DEPTH; i++) begin
      do_cap(i % 256, 1, i % 256, 1, 0);
      if (i == DEPTH - 2) check_status("t2_almost");
    end
    check_status("t2_full");
    check("t2_count_full", 32'(count), 32'(DEPTH));
    do_cap(77, 77, 5929, 1, 0);
    check_status("t2_extra");
    read_all(0);

    // Random captures with idle cycles, read back with random gaps.
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 40);
      do_arm();
      for (int k = 0; k < n; k++) begin
        int av = $urandom_range(0, 255);
        int bv = $urandom_range(0, 255);
        do_cap(av, bv, av * bv, $urandom_range(0, 3) != 0, 0);
      end
      do_cap(1, 3, 3, $urandom_range(0, 1), 1);
      check_status("rand_stop");
      read_all(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
